// File: rtl/addsub_multicycle_if.sv
// Operand/result handshake bundle for the multi-cycle add/subtract unit.
interface addsub_multicycle_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             sticky_ovf;
  logic             sticky_clr;

  modport master (
    output in_valid, a, b, op_sub, sat_en, out_ready, sticky_clr,
    input  in_ready, out_valid, result, overflow, carry, zero, negative, sticky_ovf
  );

  modport slave (
    input  in_valid, a, b, op_sub, sat_en, out_ready, sticky_clr,
    output in_ready, out_valid, result, overflow, carry, zero, negative, sticky_ovf
  );
endinterface

// File: rtl/addsub_multicycle.sv
// Multi-cycle signed add/subtract: CHUNK bits per clock through a registered carry,
// with optional saturation, status flags and a sticky overflow bit.
module addsub_multicycle #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_multicycle_if.slave  bus
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, raw_q, raw_d;
  logic             op_q, op_d, sat_q, sat_d, cy_q, cy_d, sticky_q, sticky_d;
  logic [CW-1:0]    step_q, step_d;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res;
  logic             accept, consume, ovf, last;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign consume = (state_q == DONE) && bus.out_ready;
  assign last    = (step_q == CW'(STEPS - 1));
  assign sum     = {1'b0, a_q[step_q*CHUNK +: CHUNK]} + {1'b0, b_q[step_q*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cy_q};
  assign ovf     = (a_q[MSB] == b_q[MSB]) && (raw_q[MSB] != a_q[MSB]);
  assign res     = (sat_q && ovf) ? {a_q[MSB], {(WIDTH-1){~a_q[MSB]}}} : raw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      op_q     <= 1'b0;
      sat_q    <= 1'b0;
      cy_q     <= 1'b0;
      step_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      op_q     <= op_d;
      sat_q    <= sat_d;
      cy_q     <= cy_d;
      step_q   <= step_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    op_d     = op_q;
    sat_d    = sat_q;
    cy_d     = cy_q;
    step_d   = step_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE: if (accept) begin
        a_d     = bus.a;
        b_d     = bus.op_sub ? ~bus.b : bus.b;
        op_d    = bus.op_sub;
        sat_d   = bus.sat_en;
        cy_d    = bus.op_sub;
        raw_d   = '0;
        step_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        raw_d[step_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        cy_d   = sum[CHUNK];
        step_d = step_q + CW'(1);
        if (last) state_d = DONE;
      end
      DONE: if (consume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A consumed overflow wins over a same-edge clear.
    if (consume && ovf)     sticky_d = 1'b1;
    else if (bus.sticky_clr) sticky_d = 1'b0;
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = 1'b0;
    bus.result    = '0;
    bus.overflow  = 1'b0;
    bus.carry     = 1'b0;
    bus.zero      = 1'b0;
    bus.negative  = 1'b0;
    bus.sticky_ovf = sticky_q;
    if (state_q == DONE) begin
      bus.out_valid = 1'b1;
      bus.result    = res;
      bus.overflow  = ovf;
      bus.carry     = op_q ^ cy_q;
      bus.zero      = (res == '0);
      bus.negative  = res[MSB];
    end
  end
endmodule

// File: tb/tb_addsub_multicycle.sv
// Drives four 8-bit units (CHUNK 1/2/4/8) and one 16-bit unit (CHUNK 4) in lockstep.
module tb_addsub_multicycle;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, op_sub = 1'b0, sat_en = 1'b0, out_ready = 1'b0, sticky_clr = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic [31:0] o_res [5];
  logic        o_ov [5], o_cy [5], o_z [5], o_n [5], o_vld [5], o_rdy [5], o_st [5];

  localparam int WD [5] = '{8, 8, 8, 8, 16};
  localparam int ST [5] = '{8, 4, 2, 1, 4};

  for (genvar g = 0; g < 4; g++) begin : g8
    addsub_multicycle_if #(.WIDTH(8)) bus();
    assign bus.in_valid = in_valid;
    assign bus.a = a8;
    assign bus.b = b8;
    assign bus.op_sub = op_sub;
    assign bus.sat_en = sat_en;
    assign bus.out_ready = out_ready;
    assign bus.sticky_clr = sticky_clr;
    assign o_res[g] = {24'b0, bus.result};
    assign o_ov[g] = bus.overflow;
    assign o_cy[g] = bus.carry;
    assign o_z[g] = bus.zero;
    assign o_n[g] = bus.negative;
    assign o_vld[g] = bus.out_valid;
    assign o_rdy[g] = bus.in_ready;
    assign o_st[g] = bus.sticky_ovf;
    addsub_multicycle #(.WIDTH(8), .CHUNK(8 / ST[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end

  addsub_multicycle_if #(.WIDTH(16)) w16();
  assign w16.in_valid = in_valid;
  assign w16.a = a16;
  assign w16.b = b16;
  assign w16.op_sub = op_sub;
  assign w16.sat_en = sat_en;
  assign w16.out_ready = out_ready;
  assign w16.sticky_clr = sticky_clr;
  assign o_res[4] = {16'b0, w16.result};
  assign o_ov[4] = w16.overflow;
  assign o_cy[4] = w16.carry;
  assign o_z[4] = w16.zero;
  assign o_n[4] = w16.negative;
  assign o_vld[4] = w16.out_valid;
  assign o_rdy[4] = w16.in_ready;
  assign o_st[4] = w16.sticky_ovf;
  addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(w16.slave));

  typedef struct packed {
    logic [4:0][31:0] r;
    logic [4:0]       ov;
    logic [4:0]       cy;
  } exp_t;

  exp_t sb [$];
  int   ntests = 0, nfail = 0;
  bit   st_exp [5] = '{default: 1'b0};

  task automatic chk(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s[dut%0d]: got %h expected %h", tag, g, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit sub, input bit sat,
                                output logic [31:0] r, output bit ov, output bit cy);
    logic [31:0] mask, be, raw;
    logic [32:0] s;
    mask = (32'h1 << w) - 32'h1;
    be   = sub ? (~b & mask) : b;
    s    = {1'b0, a} + {1'b0, be} + {32'b0, sub};
    raw  = s[31:0] & mask;
    ov   = (a[w-1] == be[w-1]) && (raw[w-1] != a[w-1]);
    cy   = sub ^ s[w];
    r    = (sat && ov) ? (a[w-1] ? (32'h1 << (w-1)) : (mask >> 1)) : raw;
  endfunction

  task automatic check_idle(input string tag);
    for (int g = 0; g < 5; g++) begin
      chk({tag, "_vld"}, g, {31'b0, o_vld[g]}, 32'd0);
      chk({tag, "_rdy"}, g, {31'b0, o_rdy[g]}, 32'd1);
      chk({tag, "_sticky"}, g, {31'b0, o_st[g]}, {31'b0, st_exp[g]});
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] aw, input logic [15:0] bw,
                        input bit sub, input bit sat, input int hold, input bit clr);
    exp_t e;
    logic [31:0] r;
    bit ov, cy, all;
    int lat [5];
    for (int g = 0; g < 5; g++) begin
      model(WD[g], (g == 4) ? {16'b0, aw} : {24'b0, a}, (g == 4) ? {16'b0, bw} : {24'b0, b},
            sub, sat, r, ov, cy);
      e.r[g] = r; e.ov[g] = ov; e.cy[g] = cy; lat[g] = 0;
    end
    sb.push_back(e);
    a8 = a; b8 = b; a16 = aw; b16 = bw; op_sub = sub; sat_en = sat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a8 = ~a; b8 = ~b; a16 = ~aw; b16 = ~bw; op_sub = ~sub; sat_en = ~sat;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      all = 1'b1;
      for (int g = 0; g < 5; g++) begin
        if (o_vld[g] && lat[g] == 0) lat[g] = c;
        if (lat[g] == 0) all = 1'b0;
      end
      if (all) break;
    end
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      for (int g = 0; g < 5; g++) begin
        if (h == 0) chk({tag, "_latency"}, g, lat[g], ST[g]);
        chk({tag, "_result"}, g, o_res[g], e.r[g]);
        chk({tag, "_ovf"}, g, {31'b0, o_ov[g]}, {31'b0, e.ov[g]});
        chk({tag, "_carry"}, g, {31'b0, o_cy[g]}, {31'b0, e.cy[g]});
        chk({tag, "_zero"}, g, {31'b0, o_z[g]}, {31'b0, e.r[g] == 32'd0});
        chk({tag, "_neg"}, g, {31'b0, o_n[g]}, {31'b0, e.r[g][WD[g]-1]});
        chk({tag, "_vld"}, g, {31'b0, o_vld[g]}, 32'd1);
        chk({tag, "_rdy"}, g, {31'b0, o_rdy[g]}, 32'd0);
      end
      if (h < hold) begin
        in_valid = 1'b1; a8 = 8'h5A; b8 = 8'h3C; a16 = 16'h5A5A; b16 = 16'h3C3C;
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1; sticky_clr = clr;
    @(posedge clk); #1;
    out_ready = 1'b0; sticky_clr = 1'b0;
    for (int g = 0; g < 5; g++) st_exp[g] = e.ov[g] ? 1'b1 : (clr ? 1'b0 : st_exp[g]);
    check_idle({tag, "_handoff"});
    in_valid = 1'b0;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input bit sub, input bit sat, input int hold, input bit clr);
    run_op(tag, a, b, {{8{a[7]}}, a}, {{8{b[7]}}, b}, sub, sat, hold, clr);
  endtask

  initial begin
    #12;
    for (int g = 0; g < 5; g++) begin
      chk("rst_res", g, o_res[g], 32'd0);
      chk("rst_flags", g, {28'b0, o_ov[g], o_cy[g], o_z[g], o_n[g]}, 32'd0);
    end
    check_idle("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8("add30_20", 8'h30, 8'h20, 1'b0, 1'b0, 0, 1'b0);
    op8("sub80_01", 8'h80, 8'h01, 1'b1, 1'b0, 0, 1'b0);
    op8("sub80_01s", 8'h80, 8'h01, 1'b1, 1'b1, 0, 1'b0);
    run_op("add7f_01s", 8'h7F, 8'h01, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);

    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    for (int g = 0; g < 5; g++) st_exp[g] = 1'b0;
    check_idle("sticky_clr");

    op8("ovf_and_clr", 8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b1);
    op8("sub05_05", 8'h05, 8'h05, 1'b1, 1'b0, 0, 1'b0);
    op8("sub03_05", 8'h03, 8'h05, 1'b1, 1'b0, 0, 1'b0);
    op8("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    op8("backpress", 8'h11, 8'h22, 1'b0, 1'b0, 5, 1'b0);
    op8("after_bp", 8'h40, 8'h3F, 1'b0, 1'b1, 0, 1'b0);
    run_op("pre_reset", 8'h7F, 8'h01, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    a8 = 8'h12; b8 = 8'h34; a16 = 16'h1234; b16 = 16'h0034; op_sub = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) st_exp[g] = 1'b0;
    check_idle("mid_reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    op8("sub10_20", 8'h10, 8'h20, 1'b1, 1'b0, 0, 1'b0);
    run_op("w16_neg_sat", 8'h80, 8'h7F, 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
